// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Two-button control sequencer for an MM.SS stopwatch. Sits between the board
// push-buttons and the minute/second timer plus display multiplexer.
//
// Each raw button passes through a 2-FF synchronizer and a counter-based
// debouncer. A press event is the rising edge of the debounced level. A mode
// FSM (IDLE / RUN / LAP / PAUSE) turns press events into one-cycle go/stop/clr
// pulses for the timer. It also chooses between live and frozen (lap) digits
// for the display.
//
// Optional build macro: LAP_TIMEOUT_EN
//   defined   : LAP automatically falls back to RUN after LAP_TICKS clocks
//               (no timer pulse is issued). A button event in the same cycle
//               wins over the timeout.
//   undefined : no timeout counter is built; LAP persists until a button event.
//
// Parameters
//   DB_CYCLES  consecutive stable clocks before a debounced level flips
//   DB_W       width of the debounce counter (must hold DB_CYCLES-1)
//   LAP_TICKS  lap auto-release timeout in clocks (LAP_TIMEOUT_EN only)
//
// Ports
//   clk                 system clock
//   reset               synchronous, active-low reset
//   btn_ss              raw start/stop button (active-high, asynchronous)
//   btn_lr              raw lap/reset button  (active-high, asynchronous)
//   t3,t2,t1,t0         live BCD digits from the timer (t3 = tens of minutes)
//   go, stop, clr       registered one-cycle command pulses to the timer
//   hex3..hex0          digits to the display mux
//   dp_out              decimal-point pattern to the display mux
//   running             high while in RUN or LAP (registered)
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int unsigned DB_CYCLES = 32'd1000000,
   parameter int unsigned DB_W      = 20,
   parameter int unsigned LAP_TICKS = 32'd300000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lr,
   input  logic [3:0] t3,
   input  logic [3:0] t2,
   input  logic [3:0] t1,
   input  logic [3:0] t0,
   output logic       go,
   output logic       stop,
   output logic       clr,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic [3:0] dp_out,
   output logic       running
);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // --------------------------------------------------------------------------
   if (DB_CYCLES == 0 || ((64'(DB_CYCLES) - 64'd1) >> DB_W) != 64'd0) begin : g_db_check
      $error("DB_CYCLES must be non-zero and DB_CYCLES-1 must fit in DB_W bits");
   end

   if (LAP_TICKS < 2) begin : g_lap_check
      $error("LAP_TICKS must be at least 2");
   end

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   // Decimal-point patterns: lap view marks the frozen display differently
   localparam logic [3:0] DP_LIVE = 4'b1011;
   localparam logic [3:0] DP_LAP  = 4'b0011;

   // --------------------------------------------------------------------------
   // Button conditioning: bit 0 = start/stop, bit 1 = lap/reset
   // --------------------------------------------------------------------------
   logic [1:0] raw;
   logic [1:0] press;

   assign raw = {btn_lr, btn_ss};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic            sync1_reg;
         logic            sync2_reg;
         logic            level_reg;
         logic            level_d_reg;
         logic            press_reg;
         logic [DB_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (!reset) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               level_reg   <= 1'b0;
               level_d_reg <= 1'b0;
               press_reg   <= 1'b0;
               cnt_reg     <= '0;
            end else begin
               sync1_reg <= raw[gi];
               sync2_reg <= sync1_reg;

               // The counter measures how long the synced input has disagreed
               // with the debounced level; any agreement restarts the count.
               if (sync2_reg != level_reg) begin
                  if (cnt_reg == DB_LAST) begin
                     level_reg <= sync2_reg;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + DB_W'(1);
                  end
               end else begin
                  cnt_reg <= '0;
               end

               // Registered rising-edge detect: one-cycle event per press,
               // nothing on release.
               level_d_reg <= level_reg;
               press_reg   <= level_reg & ~level_d_reg;
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   logic ss_ev;
   logic lr_ev;

   assign ss_ev = press[0];
   assign lr_ev = press[1];

   // --------------------------------------------------------------------------
   // Mode FSM
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic       go_reg;
   logic       stop_reg;
   logic       clr_reg;
   logic       go_next;
   logic       stop_next;
   logic       clr_next;
   logic       running_reg;
   logic       init_reg;
   logic       lap_load;
   logic       lap_expire;
   logic [3:0] lap3_reg;
   logic [3:0] lap2_reg;
   logic [3:0] lap1_reg;
   logic [3:0] lap0_reg;

`ifdef LAP_TIMEOUT_EN
   logic [31:0] lap_cnt_reg;

   // Held at zero outside LAP, so it always starts from zero on entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lap_cnt_reg <= '0;
      end else if (state_reg != LAP) begin
         lap_cnt_reg <= '0;
      end else begin
         lap_cnt_reg <= lap_cnt_reg + 32'd1;
      end
   end

   assign lap_expire = (state_reg == LAP) && (lap_cnt_reg == 32'(LAP_TICKS - 1));
`else
   assign lap_expire = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      go_next    = 1'b0;
      stop_next  = 1'b0;
      clr_next   = 1'b0;
      lap_load   = 1'b0;

      if (init_reg) begin
         // First clock out of reset: clear the timer to 00.00. No button
         // event can exist yet because the press registers were just reset.
         clr_next = 1'b1;
      end else begin
         // Start/stop is checked first everywhere, so a simultaneous
         // lap/reset event is simply dropped.
         case (state_reg)
            IDLE: begin
               if (ss_ev) begin
                  state_next = RUN;
                  go_next    = 1'b1;
               end else if (lr_ev) begin
                  clr_next = 1'b1;
               end
            end
            RUN: begin
               if (ss_ev) begin
                  state_next = PAUSE;
                  stop_next  = 1'b1;
               end else if (lr_ev) begin
                  state_next = LAP;
                  lap_load   = 1'b1;
               end
            end
            LAP: begin
               if (ss_ev) begin
                  state_next = PAUSE;
                  stop_next  = 1'b1;
               end else if (lr_ev || lap_expire) begin
                  state_next = RUN;
               end
            end
            PAUSE: begin
               if (ss_ev) begin
                  state_next = RUN;
                  go_next    = 1'b1;
               end else if (lr_ev) begin
                  state_next = IDLE;
                  clr_next   = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= IDLE;
         go_reg      <= 1'b0;
         stop_reg    <= 1'b0;
         clr_reg     <= 1'b0;
         running_reg <= 1'b0;
         init_reg    <= 1'b1;
         lap3_reg    <= 4'd0;
         lap2_reg    <= 4'd0;
         lap1_reg    <= 4'd0;
         lap0_reg    <= 4'd0;
      end else begin
         state_reg   <= state_next;
         go_reg      <= go_next;
         stop_reg    <= stop_next;
         clr_reg     <= clr_next;
         // Derived from the next state so it lines up with state_reg.
         running_reg <= (state_next == RUN) || (state_next == LAP);
         init_reg    <= 1'b0;
         if (lap_load) begin
            lap3_reg <= t3;
            lap2_reg <= t2;
            lap1_reg <= t1;
            lap0_reg <= t0;
         end
      end
   end

   assign go      = go_reg;
   assign stop    = stop_reg;
   assign clr     = clr_reg;
   assign running = running_reg;

   // --------------------------------------------------------------------------
   // Display selection: frozen lap digits in LAP, live digits otherwise
   // --------------------------------------------------------------------------
   always_comb begin
      hex3   = t3;
      hex2   = t2;
      hex1   = t1;
      hex0   = t0;
      dp_out = DP_LIVE;
      if (state_reg == LAP) begin
         hex3   = lap3_reg;
         hex2   = lap2_reg;
         hex1   = lap1_reg;
         hex0   = lap0_reg;
         dp_out = DP_LAP;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Directed bench for stopwatch_ctrl with DB_CYCLES=4 and LAP_TICKS=16.
// Stimulus pushes each expected timer pulse ({go,stop,clr} plus the cycle on
// which it must appear) into a queue. An independent monitor pops and compares
// whenever the DUT raises any pulse, and flags expected pulses that never came.
// Display and running are checked directly at quiet points of the sequence.
// Honours LAP_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_ss;
   logic       btn_lr;
   logic [3:0] t3, t2, t1, t0;
   logic       go, stop, clr;
   logic [3:0] hex3, hex2, hex1, hex0;
   logic [3:0] dp_out;
   logic       running;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [2:0] pulse;   // {go, stop, clr}
   } exp_t;

   exp_t exp_q[$];

   stopwatch_ctrl #(
      .DB_CYCLES (4),
      .DB_W      (20),
      .LAP_TICKS (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_ss  (btn_ss),
      .btn_lr  (btn_lr),
      .t3      (t3),
      .t2      (t2),
      .t1      (t1),
      .t0      (t0),
      .go      (go),
      .stop    (stop),
      .clr     (clr),
      .hex3    (hex3),
      .hex2    (hex2),
      .hex1    (hex1),
      .hex0    (hex0),
      .dp_out  (dp_out),
      .running (running)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------ monitor
   always @(negedge clk) begin
      exp_t e;
      if ((go | stop | clr) === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: got {go,stop,clr}=%b at cycle %0d, required none", {go, stop, clr}, cyc);
         end else begin
            e = exp_q.pop_front();
            if ({go, stop, clr} !== e.pulse || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL pulse: got {go,stop,clr}=%b at cycle %0d, required %b at cycle %0d",
                        {go, stop, clr}, cyc, e.pulse, e.cyc);
            end else begin
               $display("pulse {go,stop,clr}=%b at cycle %0d ok", {go, stop, clr}, cyc);
            end
         end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missed_pulse: got nothing by cycle %0d, required %b at cycle %0d", cyc, e.pulse, e.cyc);
      end
   end

   // ------------------------------------------------------------------ helpers
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end else begin
         $display("check %s = %0h ok (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic set_t(input logic [15:0] v);
      {t3, t2, t1, t0} = v;
   endtask

   // Press one or both buttons for 10 clocks, then leave 14 quiet clocks so the
   // debounced levels are back low. Called just after a rising edge; a pulse
   // appears DB_CYCLES+4 = 8 edges after the raw rise.
   task automatic press(input logic ss, input logic lr, input logic [2:0] pulse);
      exp_t e;
      if (pulse != 3'b000) begin
         e.cyc   = cyc + 8;
         e.pulse = pulse;
         exp_q.push_back(e);
      end
      btn_ss = ss;
      btn_lr = lr;
      step(10);
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      step(14);
   endtask

   // ------------------------------------------------------------------ stimulus
   initial begin
      exp_t e;
      reset  = 1'b0;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      set_t(16'h5678);

      // Reset held for 3 clocks
      step(3);
      @(negedge clk);
      chk("reset_pulses", {29'd0, go, stop, clr}, 32'd0);
      chk("reset_running", {31'd0, running}, 32'd0);
      chk("reset_dp", {28'd0, dp_out}, 32'hb);
      chk("reset_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h5678);

      // Release: clr exactly on the first edge after release
      step(1);
      reset   = 1'b1;
      e.cyc   = cyc + 1;
      e.pulse = 3'b001;
      exp_q.push_back(e);
      step(3);
      @(negedge clk);
      chk("idle_running", {31'd0, running}, 32'd0);
      chk("idle_dp", {28'd0, dp_out}, 32'hb);
      chk("idle_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h5678);
      step(1);

      // 3-clock glitch on start/stop: filtered, no pulse
      btn_ss = 1'b1;
      step(3);
      btn_ss = 1'b0;
      step(20);
      @(negedge clk);
      chk("glitch_running", {31'd0, running}, 32'd0);
      step(1);

      // lap/reset in IDLE: clr, stay IDLE
      press(1'b0, 1'b1, 3'b001);
      @(negedge clk);
      chk("idle_lr_running", {31'd0, running}, 32'd0);
      step(1);

      // start: IDLE -> RUN with go
      press(1'b1, 1'b0, 3'b100);
      @(negedge clk);
      chk("run_running", {31'd0, running}, 32'd1);
      chk("run_dp", {28'd0, dp_out}, 32'hb);
      step(1);

      // Lap: short 4-clock presses keep the whole lap under 16 clocks
      set_t(16'h1234);
      btn_lr = 1'b1;
      step(4);
      btn_lr = 1'b0;
      step(4);
      @(negedge clk);
      chk("lap_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h1234);
      chk("lap_dp", {28'd0, dp_out}, 32'h3);
      chk("lap_running", {31'd0, running}, 32'd1);
      set_t(16'h9876);
      step(1);
      @(negedge clk);
      chk("lap_hex_frozen", {16'd0, hex3, hex2, hex1, hex0}, 32'h1234);
      step(2);
      btn_lr = 1'b1;
      step(4);
      btn_lr = 1'b0;
      step(3);
      @(negedge clk);
      chk("lap_dp_last", {28'd0, dp_out}, 32'h3);
      step(1);
      @(negedge clk);
      chk("unlap_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h9876);
      chk("unlap_dp", {28'd0, dp_out}, 32'hb);
      chk("unlap_running", {31'd0, running}, 32'd1);
      step(15);

      // RUN -> PAUSE (stop), PAUSE -> IDLE (clr)
      press(1'b1, 1'b0, 3'b010);
      @(negedge clk);
      chk("pause_running", {31'd0, running}, 32'd0);
      chk("pause_dp", {28'd0, dp_out}, 32'hb);
      chk("pause_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h9876);
      step(1);
      press(1'b0, 1'b1, 3'b001);
      @(negedge clk);
      chk("cleared_running", {31'd0, running}, 32'd0);
      step(1);

      // Simultaneous presses in RUN: only stop, no lap
      press(1'b1, 1'b0, 3'b100);
      @(negedge clk);
      chk("run2_running", {31'd0, running}, 32'd1);
      step(1);
      press(1'b1, 1'b1, 3'b010);
      @(negedge clk);
      chk("both_running", {31'd0, running}, 32'd0);
      chk("both_dp", {28'd0, dp_out}, 32'hb);
      chk("both_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h9876);
      step(1);
      press(1'b0, 1'b1, 3'b001);
      step(1);

      // Lap timeout behaviour
      press(1'b1, 1'b0, 3'b100);
      set_t(16'h4321);
      btn_lr = 1'b1;
      step(10);
      btn_lr = 1'b0;
      set_t(16'h5555);
      step(13);
      @(negedge clk);
      chk("lap3_dp", {28'd0, dp_out}, 32'h3);
      chk("lap3_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h4321);
`ifdef LAP_TIMEOUT_EN
      step(1);
      @(negedge clk);
      chk("timeout_dp", {28'd0, dp_out}, 32'hb);
      chk("timeout_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h5555);
      chk("timeout_running", {31'd0, running}, 32'd1);
      step(1);
`else
      step(77);
      @(negedge clk);
      chk("lap_hold_dp", {28'd0, dp_out}, 32'h3);
      chk("lap_hold_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h4321);
      chk("lap_hold_running", {31'd0, running}, 32'd1);
      step(1);
      press(1'b0, 1'b1, 3'b000);
      @(negedge clk);
      chk("unlap3_dp", {28'd0, dp_out}, 32'hb);
      chk("unlap3_hex", {16'd0, hex3, hex2, hex1, hex0}, 32'h5555);
      step(1);
`endif

      // Final stop, then drain
      press(1'b1, 1'b0, 3'b010);
      @(negedge clk);
      chk("final_running", {31'd0, running}, 32'd0);
      step(20);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
